// File: rtl/exec_stage.sv
// exec_stage: IDLE/READ/EXEC/WB sequencer, accept edge -> retire 3 cycles later, in_ready low while busy.
// Define EXEC_SHIFT_EN to build the LSH/RSH barrel shifter; otherwise opcodes 7 and 8 retire as NOPs.
module exec_stage #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [AW-1:0]    in_dst,
  input  logic [AW-1:0]    in_src,
  input  logic             in_imm_sel,
  input  logic [7:0]       in_imm,
  output logic [AW-1:0]    rf_dst_addr,
  output logic [AW-1:0]    rf_src_addr,
  input  logic [WIDTH-1:0] rf_dst_data,
  input  logic [WIDTH-1:0] rf_src_data,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             rf_write,
  output logic [3:0]       flags,
  output logic             retire
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
`ifdef EXEC_SHIFT_EN
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_RSH = 4'd8;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       op_q;
  logic [AW-1:0]    dst_q;
  logic [AW-1:0]    src_q;
  logic             imm_sel_q;
  logic [7:0]       imm_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0] opa, opb, alu_res;
  logic [WIDTH:0]   sum, diff;
  logic             c_nxt, f_nxt, upd_zn, op_writes;
  logic [3:0]       flags_nxt;

  // next-state and handshake
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = ~reset;
        if (in_valid) state_nxt = S_READ;
      end
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
    end else if (state == S_IDLE && in_valid) begin
      op_q      <= in_op;
      dst_q     <= in_dst;
      src_q     <= in_src;
      imm_sel_q <= in_imm_sel;
      imm_q     <= in_imm;
    end
  end

  // ALU: operands are the regfile read data returned during EXEC
  always_comb begin
    opa     = rf_dst_data;
    opb     = imm_sel_q ? {{(WIDTH-8){imm_q[7]}}, imm_q} : rf_src_data;
    sum     = {1'b0, opa} + {1'b0, opb};
    diff    = {1'b0, opa} - {1'b0, opb};
    alu_res = '0;
    c_nxt   = flags_q[3];
    f_nxt   = flags_q[2];
    upd_zn  = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        c_nxt   = sum[WIDTH];
        f_nxt   = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
        upd_zn  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[WIDTH-1:0];
        c_nxt   = diff[WIDTH];
        f_nxt   = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
        upd_zn  = 1'b1;
      end
      OP_AND: begin
        alu_res = opa & opb;
        upd_zn  = 1'b1;
      end
      OP_OR: begin
        alu_res = opa | opb;
        upd_zn  = 1'b1;
      end
      OP_XOR: begin
        alu_res = opa ^ opb;
        upd_zn  = 1'b1;
      end
      OP_MOV: alu_res = opb;
`ifdef EXEC_SHIFT_EN
      OP_LSH: begin
        alu_res = opa << opb[3:0];
        upd_zn  = 1'b1;
      end
      OP_RSH: begin
        alu_res = opa >> opb[3:0];
        upd_zn  = 1'b1;
      end
`endif
      default: alu_res = '0;
    endcase
    flags_nxt = upd_zn ? {c_nxt, f_nxt, (alu_res == '0), alu_res[WIDTH-1]} : flags_q;
  end

  always_comb begin
    unique case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: op_writes = 1'b1;
`ifdef EXEC_SHIFT_EN
      OP_LSH, OP_RSH: op_writes = 1'b1;
`endif
      default: op_writes = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state == S_EXEC) begin
      result_q <= alu_res;
      flags_q  <= flags_nxt;
    end
  end

  // addresses stay on the latched registers from READ through WB
  always_comb begin
    rf_dst_addr = (state != S_IDLE) ? dst_q : '0;
    rf_src_addr = (state != S_IDLE) ? src_q : '0;
    rf_wdata    = (state == S_WB) ? result_q : '0;
    rf_write    = (state == S_WB) && op_writes;
    retire      = (state == S_WB);
    flags       = flags_q;
  end

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: behavioural regfile plus an instruction-level reference model checked every cycle.
module tb_exec_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [3:0]  in_dst = '0;
  logic [3:0]  in_src = '0;
  logic        in_imm_sel = 1'b0;
  logic [7:0]  in_imm = '0;
  logic [3:0]  rf_dst_addr, rf_src_addr;
  logic [15:0] rf_dst_data = '0;
  logic [15:0] rf_src_data = '0;
  logic [15:0] rf_wdata;
  logic        rf_write;
  logic [3:0]  flags;
  logic        retire;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_src(in_src), .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .rf_dst_addr(rf_dst_addr), .rf_src_addr(rf_src_addr),
    .rf_dst_data(rf_dst_data), .rf_src_data(rf_src_data),
    .rf_wdata(rf_wdata), .rf_write(rf_write), .flags(flags), .retire(retire)
  );

  // register file with registered reads, preloaded
  logic [15:0] regs [16] = '{16'h0000, 16'h0003, 16'h0005, 16'h7FFF, 16'h1234, 16'h1111, 16'h0100, 16'h00AA,
                             16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  always @(posedge clk) begin
    if (rf_write) regs[rf_dst_addr] <= rf_wdata;
    rf_dst_data <= regs[rf_dst_addr];
    rf_src_data <= regs[rf_src_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // instruction-level reference: result and flags from plain integer arithmetic
  function automatic void ref_exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] fin, output logic [15:0] r, output bit wr,
                                   output logic [3:0] fout);
    int ua, ub, sa, sb, s;
    bit c, f, zn;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = fin[3]; f = fin[2]; zn = 1'b0; wr = 1'b0; r = '0;
    case (op)
      4'd0: begin s = ua + ub; r = 16'(s); c = (s > 65535); s = sa + sb;
                  f = (s > 32767) || (s < -32768); zn = 1'b1; wr = 1'b1; end
      4'd1, 4'd6: begin r = 16'(ua - ub); c = (ua < ub); s = sa - sb;
                  f = (s > 32767) || (s < -32768); zn = 1'b1; wr = (op == 4'd1); end
      4'd2: begin r = a & b; zn = 1'b1; wr = 1'b1; end
      4'd3: begin r = a | b; zn = 1'b1; wr = 1'b1; end
      4'd4: begin r = a ^ b; zn = 1'b1; wr = 1'b1; end
      4'd5: begin r = b; wr = 1'b1; end
`ifdef EXEC_SHIFT_EN
      4'd7: begin r = 16'(ua << (ub % 16)); zn = 1'b1; wr = 1'b1; end
      4'd8: begin r = 16'(ua >> (ub % 16)); zn = 1'b1; wr = 1'b1; end
`endif
      default: wr = 1'b0;
    endcase
    fout = zn ? {c, f, (r == 16'h0000), r[15]} : fin;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mregs [16] = '{16'h0000, 16'h0003, 16'h0005, 16'h7FFF, 16'h1234, 16'h1111, 16'h0100, 16'h00AA,
                              16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  bit          active = 1'b0;
  int          t0 = 0;
  int          acc_cnt = 0;
  int          acc_at [32];
  int          commit_cnt = 0;
  int          retire_cnt = 0;
  logic [3:0]  m_dst = '0, m_src = '0;
  bit          m_wr = 1'b0;
  logic [15:0] m_res = '0;
  logic [3:0]  fl_pre = '0, fl_post = '0;

  always @(posedge clk or posedge reset) begin
    logic [15:0] bv;
    if (reset) begin
      active = 1'b0; fl_pre = '0; fl_post = '0;
    end else if (!active && in_valid) begin
      bv = in_imm_sel ? 16'($signed(in_imm)) : mregs[in_src];
      ref_exec(in_op, mregs[in_dst], bv, fl_pre, m_res, m_wr, fl_post);
      m_dst = in_dst; m_src = in_src; t0 = cyc; active = 1'b1;
      acc_at[acc_cnt % 32] = cyc;
      acc_cnt++;
    end else if (active && (cyc - t0) == 3) begin
      if (m_wr) mregs[m_dst] = m_res;
      fl_pre = fl_post; active = 1'b0; commit_cnt++;
    end
  end

  always @(negedge clk) begin
    int  ph;
    bit  wb;
    if (reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_rf_write", rf_write, 0);
      chk("rst_retire", retire, 0);
      chk("rst_flags", flags, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_addrs", {rf_dst_addr, rf_src_addr}, 0);
    end else begin
      ph = cyc - t0;
      wb = active && (ph == 3);
      if (retire) retire_cnt++;
      chk("in_ready", in_ready, !active);
      chk("rf_dst_addr", rf_dst_addr, active ? m_dst : 4'h0);
      chk("rf_src_addr", rf_src_addr, active ? m_src : 4'h0);
      chk("retire", retire, wb);
      chk("rf_write", rf_write, wb && m_wr);
      if (wb && m_wr) chk("rf_wdata", rf_wdata, m_res);
      chk("flags", flags, wb ? fl_post : fl_pre);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] src,
                       input bit isel, input logic [7:0] imm, input bit hold, input bit wait_done);
    int n;
    in_valid = 1'b1; in_op = op; in_dst = dst; in_src = src; in_imm_sel = isel; in_imm = imm;
    n = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt == n; k++) begin @(posedge clk); #1; end
    if (acc_cnt == n) chk("accept_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
    if (wait_done) begin
      for (int k = 0; k < 20 && active; k++) begin @(posedge clk); #1; end
      if (active) chk("retire_timeout", 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    issue(4'd0, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0, 1'b1);       // ADD r1,r2
    chk("add_r1", regs[1], 16'h0008);
    chk("add_flags", flags, 4'b0000);

    issue(4'd5, 4'd1, 4'd0, 1'b1, 8'h01, 1'b0, 1'b1);       // MOV r1,#1
    issue(4'd5, 4'd2, 4'd0, 1'b1, 8'h02, 1'b0, 1'b1);       // MOV r2,#2
    issue(4'd1, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0, 1'b1);       // SUB r1,r2
    chk("sub_r1", regs[1], 16'hFFFF);
    chk("sub_flags", flags, 4'b1001);
    issue(4'd6, 4'd1, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1);       // CMP r1,r1
    chk("cmp_r1", regs[1], 16'hFFFF);
    chk("cmp_flags", flags, 4'b0010);

    issue(4'd0, 4'd3, 4'd0, 1'b1, 8'h01, 1'b0, 1'b1);       // ADD r3,#1
    chk("addi_r3", regs[3], 16'h8000);
    chk("addi_flags", flags, 4'b0101);
    issue(4'd5, 4'd3, 4'd0, 1'b1, 8'hF0, 1'b0, 1'b1);       // MOV r3,#0xF0
    chk("movi_r3", regs[3], 16'hFFF0);
    chk("movi_flags", flags, 4'b0101);

    n = acc_cnt;
    issue(4'd0, 4'd4, 4'd5, 1'b0, 8'h00, 1'b1, 1'b0);       // ADD r4,r5 (valid held)
    issue(4'd0, 4'd6, 4'd4, 1'b0, 8'h00, 1'b0, 1'b1);       // ADD r6,r4
    chk("dep_r4", regs[4], 16'h2345);
    chk("dep_r6", regs[6], 16'h2445);
    chk("accept_spacing", acc_at[(n + 1) % 32] - acc_at[n % 32], 4);

    issue(4'd3, 4'd5, 4'd0, 1'b1, 8'h80, 1'b0, 1'b1);       // OR r5,#0x80
    chk("or_r5", regs[5], 16'hFF91);
    issue(4'd4, 4'd5, 4'd5, 1'b0, 8'h00, 1'b0, 1'b1);       // XOR r5,r5
    chk("xor_flags", flags, 4'b0010);
    issue(4'd2, 4'd4, 4'd0, 1'b1, 8'h0F, 1'b0, 1'b1);       // AND r4,#0x0F
    chk("and_r4", regs[4], 16'h0005);
    issue(4'd12, 4'd2, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1);      // NOP
    chk("nop_r2", regs[2], 16'h0002);
    issue(4'd8, 4'd6, 4'd0, 1'b1, 8'h04, 1'b0, 1'b1);       // RSH r6,#4
`ifdef EXEC_SHIFT_EN
    chk("rsh_r6", regs[6], 16'h0244);
`else
    chk("rsh_r6", regs[6], 16'h2445);
`endif

    issue(4'd0, 4'd7, 4'd7, 1'b0, 8'h00, 1'b0, 1'b0);       // ADD r7,r7 aborted in EXEC
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_r7", regs[7], 16'h00AA);
    chk("abort_flags", flags, 4'b0000);

    issue(4'd7, 4'd8, 4'd0, 1'b1, 8'h13, 1'b0, 1'b1);       // LSH r8,#0x13
`ifdef EXEC_SHIFT_EN
    chk("lsh_r8", regs[8], 16'h0008);
`else
    chk("lsh_r8", regs[8], 16'h0001);
`endif
    chk("lsh_flags", flags, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    chk("retire_count", retire_cnt, commit_cnt);
    for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), regs[i], mregs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
# exec_stage

Single-issue execute sequencer that sits directly downstream of the 16×16 register file. It accepts one instruction at a time over a valid/ready handshake and drives the register file's read addresses. It captures the one-cycle-late read data, computes a 16-bit ALU result plus condition flags, then drives the register file write port to retire the result. It is the block that consumes `dst_data`/`src_data` and produces `data`/`write`.

## Interface
Parameters:
- `WIDTH`, 16, datapath width. Only 16 is supported.
- `AW`, 4, register address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept an instruction.
- `in_op`  in  4  opcode (see Operation).
- `in_dst`  in  4  destination / first operand register.
- `in_src`  in  4  second operand register.
- `in_imm_sel`  in  1  replace the src operand with the sign-extended immediate.
- `in_imm`  in  8  immediate.
- `rf_dst_addr`  out  4  to regfile `dst_addr`.
- `rf_src_addr`  out  4  to regfile `src_addr`.
- `rf_dst_data`  in  16  from regfile `dst_data` (registered read).
- `rf_src_data`  in  16  from regfile `src_data`.
- `rf_wdata`  out  16  to regfile `data`.
- `rf_write`  out  1  to regfile `write`.
- `flags`  out  4  {C, F, Z, N}: carry/borrow, signed overflow, zero, negative.
- `retire`  out  1  one-cycle pulse as the instruction completes.

## Operation
- The FSM has four states: IDLE → READ → EXEC → WB → IDLE. The state register, instruction latch, result register and flags are cleared by `reset`.
- **IDLE:** `in_ready`=1. On `in_valid & in_ready` at a rising edge, latch op/dst/src/imm_sel/imm and go to READ. Otherwise stay in IDLE.
- **READ:** drive `rf_dst_addr`=latched dst and `rf_src_addr`=latched src. The regfile samples the addresses at the end of this cycle.
- **EXEC:** `rf_*_data` is valid. Operand A = `rf_dst_data`. Operand B = `in_imm_sel` ? sign-extend(imm) : `rf_src_data`. Register the result and flag updates, then go to WB.
- **WB:** `rf_dst_addr`=dst, `rf_wdata`=result, `rf_write`=1 only for writing ops, `retire`=1. Flags update at the end of EXEC. Then return to IDLE.
- Addresses are held at the latched values in EXEC and WB. They are 0 in IDLE.
- Opcodes:
  - 0 ADD: A+B; C=carry-out, F=signed overflow.
  - 1 SUB: A−B; C=1 iff A<B unsigned, F=signed overflow.
  - 2 AND, 3 OR, 4 XOR: update Z and N only.
  - 5 MOV: result B; no flag change.
  - 6 CMP: same flags as SUB; no write.
  - 7 LSH: A << B[3:0]; update Z and N.
  - 8 RSH: logical A >> B[3:0]; update Z and N.
  - 9–15 NOP: no write, no flag change, still retires.
- Z = (result==0). N = result[15]. All arithmetic is modulo 2^16.
- Shift amounts 0–15 are used as-is. Bits B[15:4] are ignored.
- Dependent back-to-back instructions need no forwarding. WB's write lands at the WB→IDLE edge, before the next READ sampling edge.

## Timing
- Reset values: `in_ready`=0 while `reset` is high and 1 after release. `rf_write`=0, `retire`=0, `flags`=0, `rf_wdata`=0, addresses=0, state=IDLE.
- Latency: accept edge at t0 gives READ in cycle t0+1, EXEC in t0+2, WB in t0+3 (write edge at the end of t0+3), and IDLE in t0+4.
- Throughput is one instruction per 4 cycles. `in_ready` is low in READ, EXEC and WB.
- `in_valid` asserted while `in_ready`=0 is ignored. Upstream holds it.
- `reset` asserted mid-instruction aborts it immediately: no write, no retire, flags cleared.
- `rf_write` and `retire` are asserted for exactly one cycle per instruction and never outside WB.

## Configuration
- `EXEC_SHIFT_EN` defined: opcodes 7 (LSH) and 8 (RSH) are implemented as above.
- `EXEC_SHIFT_EN` undefined: no barrel shifter is built. Opcodes 7 and 8 behave as NOP: no write, flags unchanged, still retire in 4 cycles.

## Test plan
- Reset with regfile preloaded r1=0x0003, r2=0x0005 → outputs at reset values, `in_ready`=1 after release. Then ADD dst=1 src=2 → r1=0x0008 at the end of cycle t0+3; flags C=0 F=0 Z=0 N=0; `retire` high only in t0+3.
- SUB r1=0x0001, r2=0x0002 → r1=0xFFFF, C=1, N=1, Z=0. Then CMP r1,r1 → Z=1, C=0, r1 unchanged, `rf_write` never asserted.
- ADD r3=0x7FFF with imm 0x01 (imm_sel=1) → r3=0x8000, F=1, N=1. Then MOVI-style MOV imm 0xF0 → r3=0xFFF0.
- Dependent pair ADD r4,r5 then ADD r6,r4, issued with `in_valid` held continuously → second instruction reads the updated r4. Accepts occur exactly 4 cycles apart, and `in_ready` is 0 during each instruction's READ, EXEC and WB.
- Assert `reset` during EXEC of ADD r7,r7 → r7 unchanged, no `retire`, flags 0, `in_ready`=1 one cycle after release.
- LSH r8=0x0001 by src 0x0013 → with `EXEC_SHIFT_EN`: r8=0x0008. Without it: r8=0x0001, flags unchanged, `retire` still pulses.
